// File: rtl/fifo_uart_tx.sv
// Drains a first-word-fall-through byte FIFO and serialises each byte as an async UART frame.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit(s).
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [7:0]  fifo_data,
  input  logic        fifo_empty,
  output logic        read_request,
  output logic        tx,
  output logic        busy,
  output logic [15:0] frames_sent
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, SETTLE, POP, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, SETTLE, POP, START, DATA, STOP} state_t;
`endif

  state_t            state;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_idx;
  logic              stop_idx;
  logic [7:0]        shreg;
  logic              baud_done;
  logic              shift_en;
`ifdef FIFO_UART_TX_PARITY_EN
  logic              parity_bit;
`endif

  assign baud_done = (baud == BAUD_LAST);
  assign shift_en  = baud_done && ((state == START) || (state == DATA));

  // Data path: the byte is captured while read_request is out, then shifted LSB first.
  always_ff @(posedge clk) begin
    if (state == POP) begin
      shreg <= fifo_data;
    end else if (shift_en) begin
      shreg <= {1'b0, shreg[7:1]};
    end
  end

`ifdef FIFO_UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (state == POP) begin
      parity_bit <= ^fifo_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      baud         <= '0;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
      read_request <= 1'b0;
      tx           <= 1'b1;
      busy         <= 1'b0;
      frames_sent  <= '0;
    end else begin
      case (state)
        IDLE: begin
          baud <= '0;
          if (ena && !fifo_empty) begin
            state <= SETTLE;
            busy  <= 1'b1;
          end
        end
        // The FIFO head may still be settling; re-check empty before popping.
        SETTLE: begin
          if (fifo_empty) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state        <= POP;
            read_request <= 1'b1;
          end
        end
        POP: begin
          read_request <= 1'b0;
          state        <= START;
          tx           <= 1'b0;
          baud         <= '0;
        end
        START: begin
          if (baud_done) begin
            baud    <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
            state   <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= parity_bit;
`else
              state    <= STOP;
              tx       <= 1'b1;
              stop_idx <= 1'b0;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shreg[0];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (baud_done) begin
            baud     <= '0;
            state    <= STOP;
            tx       <= 1'b1;
            stop_idx <= 1'b0;
          end else begin
            baud <= baud + 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_done) begin
            baud <= '0;
            if (stop_idx == STOP_LAST) begin
              state       <= IDLE;
              busy        <= 1'b0;
              frames_sent <= frames_sent + 16'd1;
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          tx           <= 1'b1;
          read_request <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a queue-based FIFO model feeds the DUT; expected serial frames are built from the byte value.
module tb_fifo_uart_tx;

  localparam int CPB   = 4;
  localparam int STOPS = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [7:0]  fifo_data;
  logic        fifo_empty;
  logic        read_request;
  logic        tx;
  logic        busy;
  logic [15:0] frames_sent;

  int          checks = 0;
  int          failures = 0;
  int          pops = 0;
  int          exp_pops = 0;
  logic [15:0] exp_frames = 16'd0;
  logic [7:0]  fifo_q[$];

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(STOPS)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .read_request(read_request), .tx(tx), .busy(busy), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic update_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    update_fifo();
  endtask

  // One clock; the FIFO pops on any edge at which read_request was high.
  task automatic tick();
    logic rr_before;
    rr_before = read_request;
    @(posedge clk);
    #1;
    if (rr_before) begin
      check("no_underflow", {31'd0, fifo_q.size() == 0}, 32'd0);
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      pops++;
      update_fifo();
    end
  endtask

  // pre = clocks with read_request low before the pop clock (1 from idle, 2 back-to-back).
  task automatic expect_frame(input logic [7:0] b, input int pre, input bit drop_ena);
    logic lv[$];
    lv.push_back(1'b0);
    for (int i = 0; i < 8; i++) lv.push_back(((b >> i) & 8'h01) != 8'h00);
`ifdef FIFO_UART_TX_PARITY_EN
    lv.push_back(($countones(b) % 2) == 1);
`endif
    for (int i = 0; i < STOPS; i++) lv.push_back(1'b1);
    for (int i = 0; i < pre; i++) begin
      tick();
      check("gap_tx", tx, 1);
      check("gap_rr", read_request, 0);
      if (i == 0 && pre == 2) begin
        check("idle_busy", busy, 0);
        check("frames_between", frames_sent, exp_frames);
      end
    end
    tick();
    check("pop_rr", read_request, 1);
    check("pop_busy", busy, 1);
    check("pop_tx", tx, 1);
    if (drop_ena) ena = 1'b0;
    foreach (lv[k]) begin
      for (int c = 0; c < CPB; c++) begin
        tick();
        check($sformatf("tx_b%02h_l%0d", b, k), tx, lv[k]);
        check("frame_rr_low", read_request, 0);
      end
    end
    exp_frames = exp_frames + 16'd1;
    exp_pops++;
  endtask

  initial begin
    logic [7:0] rb[4];
    logic [7:0] b;
    rst_n = 1'b0;
    ena   = 1'b1;
    update_fifo();
    #12;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_rr", read_request, 0);
    check("rst_frames", frames_sent, 0);
    rst_n = 1'b1;
    // Empty FIFO: nothing happens.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("empty_rr", read_request, 0);
      check("empty_tx", tx, 1);
      check("empty_busy", busy, 0);
    end

    // Single byte 0xA5.
    push(8'hA5);
    expect_frame(8'hA5, 1, 1'b0);
    tick();
    check("a5_frames", frames_sent, exp_frames);
    check("a5_busy", busy, 0);
    check("a5_pops", pops, exp_pops);

    // Three queued bytes back to back.
    push(8'h01); push(8'h80); push(8'hFF);
    expect_frame(8'h01, 1, 1'b0);
    expect_frame(8'h80, 2, 1'b0);
    expect_frame(8'hFF, 2, 1'b0);
    tick();
    check("three_frames", frames_sent, exp_frames);
    check("three_pops", pops, exp_pops);

    // FIFO goes empty while the DUT is settling.
    repeat (3) tick();
    push(8'h3C);
    tick();
    check("settle_busy", busy, 1);
    void'(fifo_q.pop_front());
    update_fifo();
    for (int i = 0; i < 6; i++) begin
      tick();
      check("settle_abort_rr", read_request, 0);
      check("settle_abort_busy", busy, 0);
      check("settle_abort_tx", tx, 1);
    end
    check("settle_pops", pops, exp_pops);

    // ena dropped mid-frame: frame completes, next byte waits.
    push(8'h5A); push(8'hC3);
    expect_frame(8'h5A, 1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("ena_off_rr", read_request, 0);
      check("ena_off_tx", tx, 1);
    end
    check("ena_off_frames", frames_sent, exp_frames);
    check("ena_off_pops", pops, exp_pops);
    check("ena_off_left", fifo_q.size(), 1);
    ena = 1'b1;
    expect_frame(8'hC3, 1, 1'b0);
    tick();
    check("ena_on_frames", frames_sent, exp_frames);

    // Reset in the middle of data bit 3.
    b = 8'($urandom_range(0, 255));
    push(b);
    tick();
    tick();
    check("rstmid_pop", read_request, 1);
    exp_pops++;
    repeat (CPB + 3 * CPB + 2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_tx", tx, 1);
    check("rstmid_busy", busy, 0);
    check("rstmid_rr", read_request, 0);
    exp_frames = 16'd0;
    check("rstmid_frames", frames_sent, exp_frames);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3 * CPB; i++) begin
      tick();
      check("post_rst_tx", tx, 1);
    end
    check("post_rst_frames", frames_sent, exp_frames);
    b = 8'($urandom_range(0, 255));
    push(b);
    expect_frame(b, 1, 1'b0);
    tick();
    check("restart_frames", frames_sent, exp_frames);

    // Random bytes, back to back.
    for (int i = 0; i < 4; i++) begin
      rb[i] = 8'($urandom_range(0, 255));
      push(rb[i]);
    end
    for (int i = 0; i < 4; i++) expect_frame(rb[i], (i == 0) ? 1 : 2, 1'b0);
    tick();
    check("rand_frames", frames_sent, exp_frames);
    check("rand_pops", pops, exp_pops);
    check("rand_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
